serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 156 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder controller. Operands are captured on an accepted start
//   and fed LSB-first, one bit per clock, to an external one-bit full adder.
//   The returned sum bits are collected, and the completed result is
//   published together with a one-cycle done pulse.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   add request, sampled only while idle
//   A_in      in   operand A (WIDTH), captured on accepted start
//   B_in      in   operand B (WIDTH), captured on accepted start
//   Cin_in    in   initial carry, captured on accepted start
//   fa_A      out  operand A bit to the external full adder
//   fa_B      out  operand B bit to the external full adder
//   fa_Cin    out  carry to the external full adder
//   fa_Sum    in   sum bit from the external full adder
//   fa_Cout   in   carry-out from the external full adder
//   busy      out  high whenever an add is in progress or completing
//   done      out  one-cycle pulse when Sum_out/Cout_out hold a new result
//   Sum_out   out  last completed sum (WIDTH), held until the next completion
//   Cout_out  out  last completed carry-out, held until the next completion
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Cin_in,
  output logic             fa_A,
  output logic             fa_B,
  output logic             fa_Cin,
  input  logic             fa_Sum,
  input  logic             fa_Cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum_out,
  output logic             Cout_out
);

  // One extra bit beyond ceil(log2(WIDTH)) so the counter never wraps,
  // including the WIDTH=1 case where $clog2 returns 0.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout_out;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nxt;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_RUN);
  assign w_last = w_step && (r_cnt == LAST_CNT);

  // Sum register shifts right with the new bit entering at the MSB, so after
  // WIDTH steps the first (LSB) sum bit has reached position 0.
  always_comb begin
    w_sum_nxt            = r_sum_sh >> 1;
    w_sum_nxt[WIDTH-1]   = fa_Sum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    fa_A        = 1'b0;
    fa_B        = 1'b0;
    fa_Cin      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        fa_A   = r_a_sh[0];
        fa_B   = r_b_sh[0];
        fa_Cin = r_carry;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, serial stepping and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
    end else if (w_load) begin
      r_a_sh   <= A_in;
      r_b_sh   <= B_in;
      r_sum_sh <= '0;
      r_carry  <= Cin_in;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_nxt;
      r_carry  <= fa_Cout;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum_out  <= w_sum_nxt;
        r_cout_out <= fa_Cout;
      end
    end
  end

  assign Sum_out  = r_sum_out;
  assign Cout_out = r_cout_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Drives a WIDTH=8 and a WIDTH=1 instance, each wired to a behavioural
//   full adder, and compares every cycle against a reference model that
//   computes results and per-bit carries directly from integer addition.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=8 instance
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic         busy, done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_adder_ctrl #(.WIDTH(W)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A_in     (a_in),
    .B_in     (b_in),
    .Cin_in   (cin_in),
    .fa_A     (fa_a),
    .fa_B     (fa_b),
    .fa_Cin   (fa_cin),
    .fa_Sum   (fa_sum),
    .fa_Cout  (fa_cout),
    .busy     (busy),
    .done     (done),
    .Sum_out  (sum_out),
    .Cout_out (cout_out)
  );

  // WIDTH=1 instance
  logic       start1;
  logic [0:0] a1, b1;
  logic       c1;
  logic       fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1;

  assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .A_in     (a1),
    .B_in     (b1),
    .Cin_in   (c1),
    .fa_A     (fa_a1),
    .fa_B     (fa_b1),
    .fa_Cin   (fa_cin1),
    .fa_Sum   (fa_sum1),
    .fa_Cout  (fa_cout1),
    .busy     (busy1),
    .done     (done1),
    .Sum_out  (sum1),
    .Cout_out (cout1)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Last completed result as seen by the model
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle. restart_at >= 0 pulses start with
  // new operands during that RUN cycle; hold keeps start high throughout.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit hold, input bit scramble, input int restart_at);
    longint unsigned total;
    longint unsigned msk;
    longint unsigned carry_i;
    total  = longint'(a) + longint'(b) + longint'(cin);
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    cin_in = cin;
    @(negedge clk);
    for (int i = 0; i < W; i++) begin
      if (!hold) start = (i == restart_at);
      if (i == restart_at) begin
        a_in = 8'h01;
        b_in = 8'h01;
      end else if (scramble) begin
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        cin_in = 1'($urandom);
      end
      msk     = (64'd1 << i) - 64'd1;
      carry_i = ((longint'(a) & msk) + (longint'(b) & msk) + longint'(cin)) >> i;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_fa_a", fa_a, a[i]);
      chk("run_fa_b", fa_b, b[i]);
      chk("run_fa_cin", fa_cin, carry_i);
      chk("run_sum_hold", sum_out, exp_sum);
      chk("run_cout_hold", cout_out, exp_cout);
      @(negedge clk);
    end
    if (!hold) start = 1'b0;
    exp_sum  = total[W-1:0];
    exp_cout = total[W];
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_fa_a", fa_a, 0);
    chk("done_fa_cin", fa_cin, 0);
    chk("done_sum", sum_out, exp_sum);
    chk("done_cout", cout_out, exp_cout);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_fa", {fa_a, fa_b, fa_cin}, 0);
    chk("idle_sum_hold", sum_out, exp_sum);
    chk("idle_cout_hold", cout_out, exp_cout);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    a_in     = 8'hFF;
    b_in     = 8'hFF;
    cin_in   = 1'b1;
    start1   = 1'b1;
    a1       = 1'b1;
    b1       = 1'b1;
    c1       = 1'b1;
    exp_sum  = '0;
    exp_cout = 1'b0;

    // Reset state, with start held to show it is ignored under reset
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_cout", cout_out, 0);
    chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_sum1", {sum1, cout1}, 0);
    rst_n  = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;

    // Directed operands
    do_add(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    do_add(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, -1);
    do_add(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, -1);
    // start re-pulsed during RUN cycle 3 must be ignored
    do_add(8'h3C, 8'h42, 1'b0, 1'b0, 1'b0, 3);
    do_add(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, -1);

    // Reset mid-RUN aborts and clears the published result
    start  = 1'b1;
    a_in   = 8'h55;
    b_in   = 8'h22;
    cin_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum_out, 0);
    chk("abort_cout", cout_out, 0);
    chk("abort_fa", {fa_a, fa_b, fa_cin}, 0);
    exp_sum  = '0;
    exp_cout = 1'b0;
    @(negedge clk);
    chk("abort_no_done", done, 0);
    rst_n = 1'b1;
    do_add(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, -1);

    // start held high: back-to-back adds every W+2 cycles
    for (int n = 0; n < 4; n++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0, -1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("post_hold_idle", busy, 0);

    // Random operands, optionally disturbing inputs after capture
    for (int n = 0; n < 20; n++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'($urandom), -1);
    end

    // WIDTH=1: every operand combination
    for (int v = 0; v < 8; v++) begin
      logic [2:0] v3;
      int         t;
      v3     = 3'(v);
      a1     = v3[0];
      b1     = v3[1];
      c1     = v3[2];
      t      = int'(v3[0]) + int'(v3[1]) + int'(v3[2]);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_run_busy", busy1, 1);
      chk("w1_run_done", done1, 0);
      chk("w1_fa", {fa_a1, fa_b1, fa_cin1}, {v3[0], v3[1], v3[2]});
      @(negedge clk);
      chk("w1_done", done1, 1);
      chk("w1_sum", sum1, t % 2);
      chk("w1_cout", cout1, t / 2);
      @(negedge clk);
      chk("w1_idle_busy", busy1, 0);
      chk("w1_idle_done", done1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
